// File: rtl/control_unit.sv
// Multi-cycle instruction sequencer: fetches into an internal IR, decodes it and
// steers the datapath through ALU, shift, memory, branch and jump-and-link flows.
module control_unit #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] memdata,
    input  logic             memReady,
    input  logic [7:0]       PSR,
    output logic             PCEN,
    output logic             PSREN,
    output logic             nextInstruction,
    output logic             updateAddress,
    output logic             StoreReg,
    output logic             WriteData,
    output logic             regWrite,
    output logic             ZeroExtend,
    output logic             PCinstruction,
    output logic             SrcB,
    output logic             shiftType,
    output logic             resultEn,
    output logic             immediateRegEN,
    output logic [3:0]       ALUcond,
    output logic             jumpEN,
    output logic             BranchEN,
    output logic             jalEN,
    output logic [1:0]       chooseResult,
    output logic             memWrite
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_ALU, S_SHIFT, S_WB, S_PCINC,
        S_LOAD, S_STORE, S_BRANCH, S_JCOND, S_JAL, S_JALWB
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] ir;
    logic [3:0]       op;
    logic [3:0]       cnd;
    logic [3:0]       opext;
    logic             cond_true;
    logic             unused_bits;

    assign op    = ir[15:12];
    assign cnd   = ir[11:8];
    assign opext = ir[7:4];
    assign unused_bits = ^{PSR[4:3], PSR[1], ir[3:0], ir >> 16};

    // Instruction register, captured only on a completed fetch
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ir <= '0;
        else if (state == S_FETCH && memReady) ir <= memdata;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_FETCH;
        else        state <= state_next;
    end

    // Branch/jump condition evaluated against the registered flags
    always_comb begin
        cond_true = 1'b0;
        unique case (cnd)
            4'b0000: cond_true =  PSR[6];
            4'b0001: cond_true = !PSR[6];
            4'b0010: cond_true =  PSR[0];
            4'b0011: cond_true = !PSR[0];
            4'b0100: cond_true =  PSR[2];
            4'b0101: cond_true = !PSR[2];
            4'b0110: cond_true =  PSR[7];
            4'b0111: cond_true = !PSR[7];
            4'b1000: cond_true =  PSR[5];
            4'b1001: cond_true = !PSR[5];
            4'b1010: cond_true = !PSR[2] && !PSR[6];
            4'b1011: cond_true =  PSR[2] ||  PSR[6];
            4'b1100: cond_true = !PSR[7] && !PSR[6];
            4'b1101: cond_true =  PSR[7] ||  PSR[6];
            4'b1110: cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_FETCH:  if (memReady) state_next = S_DECODE;
            S_DECODE: begin
                unique case (op)
                    4'b0000, 4'b0001, 4'b0010, 4'b0011,
                    4'b0101, 4'b0110, 4'b1001, 4'b1011: state_next = S_ALU;
                    4'b1000: state_next = S_SHIFT;
                    4'b1100: state_next = S_BRANCH;
                    4'b0100: begin
                        unique case (opext)
                            4'b0000: state_next = S_LOAD;
                            4'b0100: state_next = S_STORE;
                            4'b1000: state_next = S_JAL;
                            4'b1100: state_next = S_JCOND;
                            default: state_next = S_PCINC;
                        endcase
                    end
                    default: state_next = S_PCINC;
                endcase
            end
            S_ALU: begin
                // Compares only update flags, so they skip write-back
                if ((op == 4'b0000 && opext == 4'b1011) || op == 4'b1011) state_next = S_PCINC;
                else state_next = S_WB;
            end
            S_SHIFT:  state_next = S_WB;
            S_LOAD:   if (memReady) state_next = S_FETCH;
            S_JAL:    state_next = S_JALWB;
            default:  state_next = S_FETCH;
        endcase
    end

    // Moore outputs; reset masks everything except the PC-sourced address select
    always_comb begin
        PCEN = 1'b0; PSREN = 1'b0; nextInstruction = 1'b0; updateAddress = 1'b0;
        StoreReg = 1'b0; WriteData = 1'b0; regWrite = 1'b0; ZeroExtend = 1'b0;
        PCinstruction = 1'b0; SrcB = 1'b0; shiftType = 1'b0; resultEn = 1'b0;
        immediateRegEN = 1'b0; ALUcond = 4'b0000; jumpEN = 1'b0; BranchEN = 1'b0;
        jalEN = 1'b0; chooseResult = 2'b00; memWrite = 1'b0;
        if (!reset) begin
            updateAddress = 1'b1;
        end else begin
            unique case (state)
                S_FETCH: begin
                    updateAddress   = 1'b1;
                    nextInstruction = memReady;
                end
                S_DECODE: begin
                    immediateRegEN = 1'b1;
                    ZeroExtend     = (op == 4'b0001) || (op == 4'b0010) || (op == 4'b0011);
                end
                S_ALU: begin
                    ALUcond      = (op == 4'b0000) ? opext : op;
                    SrcB         = (op == 4'b0000);
                    resultEn     = 1'b1;
                    chooseResult = 2'b01;
                    PSREN        = 1'b1;
                end
                S_SHIFT: begin
                    resultEn  = 1'b1;
                    shiftType = ir[4];
                    SrcB      = (opext == 4'b0100);
                end
                S_WB: begin
                    regWrite  = 1'b1;
                    WriteData = 1'b1;
                    PCEN      = 1'b1;
                end
                S_PCINC: PCEN = 1'b1;
                S_LOAD: begin
                    regWrite = memReady;
                    PCEN     = memReady;
                end
                S_STORE: begin
                    StoreReg = 1'b1;
                    memWrite = 1'b1;
                    PCEN     = 1'b1;
                end
                S_BRANCH: begin
                    PCinstruction = 1'b1;
                    BranchEN      = cond_true;
                    PCEN          = 1'b1;
                end
                S_JCOND: begin
                    SrcB   = 1'b1;
                    jumpEN = cond_true;
                    PCEN   = 1'b1;
                end
                S_JAL: begin
                    jalEN        = 1'b1;
                    jumpEN       = 1'b1;
                    SrcB         = 1'b1;
                    chooseResult = 2'b11;
                    resultEn     = 1'b1;
                    PCEN         = 1'b1;
                end
                S_JALWB: begin
                    regWrite  = 1'b1;
                    WriteData = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: walks each instruction class cycle by cycle and
// compares the full control-output vector against hand-derived values.
module tb_control_unit;

    localparam logic [22:0] PCEN_B = 23'h400000, PSREN_B = 23'h200000, NI_B   = 23'h100000;
    localparam logic [22:0] UA_B   = 23'h080000, SR_B    = 23'h040000, WD_B   = 23'h020000;
    localparam logic [22:0] RW_B   = 23'h010000, ZE_B    = 23'h008000, PCI_B  = 23'h004000;
    localparam logic [22:0] SRCB_B = 23'h002000, SHT_B   = 23'h001000, RES_B  = 23'h000800;
    localparam logic [22:0] IMM_B  = 23'h000400, JMP_B   = 23'h000020, BR_B   = 23'h000010;
    localparam logic [22:0] JAL_B  = 23'h000008, CR_ALU  = 23'h000002, CR_LNK = 23'h000006;
    localparam logic [22:0] MW_B   = 23'h000001;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] memdata;
    logic        memReady;
    logic [7:0]  PSR;
    logic PCEN, PSREN, nextInstruction, updateAddress, StoreReg, WriteData, regWrite;
    logic ZeroExtend, PCinstruction, SrcB, shiftType, resultEn, immediateRegEN;
    logic jumpEN, BranchEN, jalEN, memWrite;
    logic [3:0]  ALUcond;
    logic [1:0]  chooseResult;
    logic [22:0] obs;
    logic [22:0] expv;
    int          n_checks = 0;
    int          n_fail = 0;

    control_unit #(.WIDTH(16)) dut (
        .clk(clk), .reset(reset), .memdata(memdata), .memReady(memReady), .PSR(PSR),
        .PCEN(PCEN), .PSREN(PSREN), .nextInstruction(nextInstruction),
        .updateAddress(updateAddress), .StoreReg(StoreReg), .WriteData(WriteData),
        .regWrite(regWrite), .ZeroExtend(ZeroExtend), .PCinstruction(PCinstruction),
        .SrcB(SrcB), .shiftType(shiftType), .resultEn(resultEn),
        .immediateRegEN(immediateRegEN), .ALUcond(ALUcond), .jumpEN(jumpEN),
        .BranchEN(BranchEN), .jalEN(jalEN), .chooseResult(chooseResult), .memWrite(memWrite)
    );

    assign obs = {PCEN, PSREN, nextInstruction, updateAddress, StoreReg, WriteData, regWrite,
                  ZeroExtend, PCinstruction, SrcB, shiftType, resultEn, immediateRegEN,
                  ALUcond, jumpEN, BranchEN, jalEN, chooseResult, memWrite};

    always #5 clk = ~clk;

    function automatic logic [22:0] alu_f(input logic [3:0] c);
        return 23'(c) << 6;
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Completes a fetch from FETCH; leaves the DUT in DECODE with memReady low
    task automatic fetch(input logic [15:0] instr);
        memdata  = instr;
        memReady = 1'b1;
        tick();
        memReady = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; memReady = 1'b1; memdata = 16'h0051; PSR = 8'h00;
        repeat (2) tick();
        n_checks++; if (obs !== UA_B) begin n_fail++; $display("FAIL reset_hold: got %h expected %h", obs, UA_B); end
        reset = 1'b1;
        #1;
        n_checks++; if (obs !== (UA_B | NI_B)) begin n_fail++; $display("FAIL reset_release_fetch: got %h expected %h", obs, UA_B | NI_B); end
    endtask

    task automatic test_add();
        tick(); memReady = 1'b0; #1;
        n_checks++; if (obs !== IMM_B) begin n_fail++; $display("FAIL add_decode: got %h expected %h", obs, IMM_B); end
        tick();
        expv = alu_f(4'h5) | PSREN_B | RES_B | SRCB_B | CR_ALU;
        n_checks++; if (obs !== expv) begin n_fail++; $display("FAIL add_alu: got %h expected %h", obs, expv); end
        tick();
        n_checks++; if (obs !== (PCEN_B | WD_B | RW_B)) begin n_fail++; $display("FAIL add_wb: got %h expected %h", obs, PCEN_B | WD_B | RW_B); end
        tick();
        n_checks++; if (obs !== UA_B) begin n_fail++; $display("FAIL add_refetch: got %h expected %h", obs, UA_B); end
    endtask

    task automatic test_fetch_wait();
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (obs !== UA_B) begin n_fail++; $display("FAIL fetch_wait%0d: got %h expected %h", i, obs, UA_B); end
            tick();
        end
        memdata = 16'hF000; memReady = 1'b1; #1;
        n_checks++; if (obs !== (UA_B | NI_B)) begin n_fail++; $display("FAIL fetch_ready: got %h expected %h", obs, UA_B | NI_B); end
        tick(); memReady = 1'b0; #1;
        n_checks++; if (obs !== IMM_B) begin n_fail++; $display("FAIL undef_decode: got %h expected %h", obs, IMM_B); end
        tick();
        n_checks++; if (obs !== PCEN_B) begin n_fail++; $display("FAIL undef_pcinc: got %h expected %h", obs, PCEN_B); end
        tick();
        n_checks++; if (obs !== UA_B) begin n_fail++; $display("FAIL undef_refetch: got %h expected %h", obs, UA_B); end
    endtask

    task automatic test_imm_compare();
        fetch(16'h1234);
        n_checks++; if (obs !== (IMM_B | ZE_B)) begin n_fail++; $display("FAIL addi_decode_ze: got %h expected %h", obs, IMM_B | ZE_B); end
        tick();
        expv = alu_f(4'h1) | PSREN_B | RES_B | CR_ALU;
        n_checks++; if (obs !== expv) begin n_fail++; $display("FAIL addi_alu: got %h expected %h", obs, expv); end
        tick();
        n_checks++; if (obs !== (PCEN_B | WD_B | RW_B)) begin n_fail++; $display("FAIL addi_wb: got %h expected %h", obs, PCEN_B | WD_B | RW_B); end
        tick();
        fetch(16'hB123);
        n_checks++; if (obs !== IMM_B) begin n_fail++; $display("FAIL cmpi_decode_se: got %h expected %h", obs, IMM_B); end
        tick();
        expv = alu_f(4'hB) | PSREN_B | RES_B | CR_ALU;
        n_checks++; if (obs !== expv) begin n_fail++; $display("FAIL cmpi_alu: got %h expected %h", obs, expv); end
        tick();
        n_checks++; if (obs !== PCEN_B) begin n_fail++; $display("FAIL cmpi_no_wb: got %h expected %h", obs, PCEN_B); end
        tick();
        fetch(16'h00B0);
        tick();
        expv = alu_f(4'hB) | PSREN_B | RES_B | SRCB_B | CR_ALU;
        n_checks++; if (obs !== expv) begin n_fail++; $display("FAIL cmp_alu: got %h expected %h", obs, expv); end
        tick();
        n_checks++; if (obs !== PCEN_B) begin n_fail++; $display("FAIL cmp_no_wb: got %h expected %h", obs, PCEN_B); end
        tick();
        fetch(16'h4010);
        tick();
        n_checks++; if (obs !== PCEN_B) begin n_fail++; $display("FAIL op4_undef_pcinc: got %h expected %h", obs, PCEN_B); end
        tick();
    endtask

    task automatic test_branch();
        PSR = 8'h40;
        fetch(16'hC005);
        tick();
        n_checks++; if (obs !== (PCI_B | BR_B | PCEN_B)) begin n_fail++; $display("FAIL beq_taken: got %h expected %h", obs, PCI_B | BR_B | PCEN_B); end
        tick();
        n_checks++; if (obs !== UA_B) begin n_fail++; $display("FAIL beq_refetch: got %h expected %h", obs, UA_B); end
        PSR = 8'h00;
        fetch(16'hC005);
        tick();
        n_checks++; if (obs !== (PCI_B | PCEN_B)) begin n_fail++; $display("FAIL beq_not_taken: got %h expected %h", obs, PCI_B | PCEN_B); end
        tick();
    endtask

    task automatic test_load();
        fetch(16'h4302);
        tick();
        n_checks++; if (obs !== 23'h0) begin n_fail++; $display("FAIL load_wait0: got %h expected %h", obs, 23'h0); end
        tick();
        n_checks++; if (obs !== 23'h0) begin n_fail++; $display("FAIL load_wait1: got %h expected %h", obs, 23'h0); end
        tick();
        memReady = 1'b1; #1;
        n_checks++; if (obs !== (RW_B | PCEN_B)) begin n_fail++; $display("FAIL load_ready: got %h expected %h", obs, RW_B | PCEN_B); end
        tick(); memReady = 1'b0; #1;
        n_checks++; if (obs !== UA_B) begin n_fail++; $display("FAIL load_refetch: got %h expected %h", obs, UA_B); end
    endtask

    task automatic test_store();
        fetch(16'h4340);
        tick();
        n_checks++; if (obs !== (SR_B | MW_B | PCEN_B)) begin n_fail++; $display("FAIL store: got %h expected %h", obs, SR_B | MW_B | PCEN_B); end
        tick();
        n_checks++; if (obs !== UA_B) begin n_fail++; $display("FAIL store_one_cycle: got %h expected %h", obs, UA_B); end
    endtask

    task automatic test_jal();
        fetch(16'h4184);
        tick();
        expv = JAL_B | JMP_B | SRCB_B | CR_LNK | RES_B | PCEN_B;
        n_checks++; if (obs !== expv) begin n_fail++; $display("FAIL jal: got %h expected %h", obs, expv); end
        tick();
        n_checks++; if (obs !== (RW_B | WD_B)) begin n_fail++; $display("FAIL jal_wb: got %h expected %h", obs, RW_B | WD_B); end
        tick();
        n_checks++; if (obs !== UA_B) begin n_fail++; $display("FAIL jal_refetch: got %h expected %h", obs, UA_B); end
    endtask

    task automatic test_jcond();
        logic [15:0] ins [8];
        logic [7:0]  flg [8];
        logic        tkn [8];
        ins = '{16'h4EC0, 16'h4FC0, 16'h4AC0, 16'h4AC0, 16'h4BC0, 16'h42C0, 16'h47C0, 16'h48C0};
        flg = '{8'h00,    8'h00,    8'h00,    8'h04,    8'h40,    8'h01,    8'h80,    8'h20};
        tkn = '{1'b1,     1'b0,     1'b1,     1'b0,     1'b1,     1'b1,     1'b0,     1'b1};
        for (int i = 0; i < 8; i++) begin
            PSR = flg[i];
            fetch(ins[i]);
            tick();
            expv = SRCB_B | PCEN_B | (tkn[i] ? JMP_B : 23'h0);
            n_checks++; if (obs !== expv) begin n_fail++; $display("FAIL jcond_%h_psr%h: got %h expected %h", ins[i], flg[i], obs, expv); end
            tick();
        end
        PSR = 8'h00;
    endtask

    task automatic test_shift();
        fetch(16'h8140);
        tick();
        n_checks++; if (obs !== (RES_B | SRCB_B)) begin n_fail++; $display("FAIL shift_reg: got %h expected %h", obs, RES_B | SRCB_B); end
        tick();
        n_checks++; if (obs !== (PCEN_B | WD_B | RW_B)) begin n_fail++; $display("FAIL shift_wb: got %h expected %h", obs, PCEN_B | WD_B | RW_B); end
        tick();
        fetch(16'h8150);
        tick();
        n_checks++; if (obs !== (RES_B | SHT_B)) begin n_fail++; $display("FAIL shift_imm: got %h expected %h", obs, RES_B | SHT_B); end
        tick();
        tick();
    endtask

    task automatic test_reset_mid_wb();
        fetch(16'h0051);
        tick();
        tick();
        n_checks++; if (obs !== (PCEN_B | WD_B | RW_B)) begin n_fail++; $display("FAIL mid_wb_before: got %h expected %h", obs, PCEN_B | WD_B | RW_B); end
        reset = 1'b0; #1;
        n_checks++; if (obs !== UA_B) begin n_fail++; $display("FAIL mid_wb_abort: got %h expected %h", obs, UA_B); end
        tick();
        reset = 1'b1; #1;
        n_checks++; if (obs !== UA_B) begin n_fail++; $display("FAIL post_reset_fetch: got %h expected %h", obs, UA_B); end
        fetch(16'hF000);
        n_checks++; if (obs !== IMM_B) begin n_fail++; $display("FAIL post_reset_decode: got %h expected %h", obs, IMM_B); end
        tick();
        n_checks++; if (obs !== PCEN_B) begin n_fail++; $display("FAIL post_reset_pcinc: got %h expected %h", obs, PCEN_B); end
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_add();
        test_fetch_wait();
        test_imm_compare();
        test_branch();
        test_load();
        test_store();
        test_jal();
        test_jcond();
        test_shift();
        test_reset_mid_wb();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 16, the data/instruction width.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port memdata  input  WIDTH  memory read data (instruction or load data).
REQ-005 SHALL have port memReady  input  1  memory read data valid this cycle.
REQ-006 SHALL have port PSR  input  8  registered flags from datapath: C=bit0, L=bit2, F=bit5, Z=bit6, N=bit7.
REQ-007 SHALL have port PCEN  output  1  PC register load.
REQ-008 SHALL have port PSREN  output  1  PSR register load.
REQ-009 SHALL have port nextInstruction  output  1  instruction register load.
REQ-010 SHALL have port updateAddress  output  1  1 = address from PC, 0 = from register.
REQ-011 SHALL have port StoreReg  output  1  store data from register file.
REQ-012 SHALL have port WriteData  output  1  1 = write back result, 0 = write back memdata.
REQ-013 SHALL have port regWrite  output  1  register file write.
REQ-014 SHALL have port ZeroExtend  output  1  1 = zero-extend, 0 = sign-extend immediate.
REQ-015 SHALL have port PCinstruction  output  1  src1 = PC.
REQ-016 SHALL have port SrcB  output  1  1 = register, 0 = immediate for src2.
REQ-017 SHALL have port shiftType  output  1  shift direction/kind.
REQ-018 SHALL have port resultEn  output  1  result register load.
REQ-019 SHALL have port immediateRegEN  output  1  immediate register load.
REQ-020 SHALL have port ALUcond  output  4  ALU operation code.
REQ-021 SHALL have port jumpEN, BranchEN, jalEN  output  1 each  PC-ALU mode selects.
REQ-022 SHALL have port chooseResult  output  2  00 shift, 01 ALU, 10 PC-ALU, 11 link.
REQ-023 SHALL have port memWrite  output  1  memory write strobe.

Function
REQ-024 SHALL hold an internal WIDTH-bit IR loaded from memdata on FETCH with memReady=1; decoding uses IR: op=IR[15:12], rd/cond=IR[11:8], opext=IR[7:4].
REQ-025 SHALL implement states FETCH, DECODE, ALU, SHIFT, WB, PCINC, LOAD, STORE, BRANCH, JCOND, JAL, JALWB; Moore outputs except strobes gated by memReady; unlisted outputs 0.
REQ-026 FETCH: updateAddress=1; stay while memReady=0; on memReady=1 nextInstruction=1, IR<=memdata, go DECODE.
REQ-027 DECODE: immediateRegEN=1, ZeroExtend=1 iff op in {0001,0010,0011}; next: op 0000/0001/0010/0011/0101/0110/1001/1011 -> ALU; 1000 -> SHIFT; 0100 with opext 0000 LOAD, 0100 STORE, 1000 JAL, 1100 JCOND; 1100 -> BRANCH; anything else -> PCINC.
REQ-028 ALU: ALUcond=opext if op=0000 else op; SrcB=1 iff op=0000; resultEn=1, chooseResult=01, PSREN=1; next PCINC if compare (op=0000&opext=1011, or op=1011) else WB.
REQ-029 SHIFT: chooseResult=00, resultEn=1, shiftType=IR[4], SrcB=1 iff opext=0100; next WB.
REQ-030 WB: regWrite=1, WriteData=1, PCEN=1 (jumpEN=BranchEN=jalEN=0, PC+1); next FETCH. PCINC: PCEN=1 only; next FETCH.
REQ-031 LOAD: updateAddress=0; wait on memReady; on memReady=1 regWrite=1, WriteData=0, PCEN=1, go FETCH.
REQ-032 STORE: updateAddress=0, StoreReg=1, memWrite=1, PCEN=1, exactly one cycle; next FETCH.
REQ-033 Condition cond=IR[11:8]: 0000 Z; 0001 !Z; 0010 C; 0011 !C; 0100 L; 0101 !L; 0110 N; 0111 !N; 1000 F; 1001 !F; 1010 !L&!Z; 1011 L|Z; 1100 !N&!Z; 1101 N|Z; 1110 1; 1111 0.
REQ-034 BRANCH: PCinstruction=1, SrcB=0, BranchEN=cond, PCEN=1; JCOND: SrcB=1, jumpEN=cond, PCEN=1; false cond yields PC+1; next FETCH.
REQ-035 JAL: jalEN=1, jumpEN=1, SrcB=1, chooseResult=11, resultEn=1, PCEN=1; next JALWB: regWrite=1, WriteData=1, no PCEN; next FETCH.
REQ-036 No instruction SHALL assert PCEN in more than one cycle; memWrite and regWrite never together.

Reset
REQ-037 reset=0 SHALL immediately force state FETCH, IR=0, and all strobes (PCEN, PSREN, regWrite, memWrite, nextInstruction, resultEn, immediateRegEN) to 0 regardless of memReady; updateAddress=1.
REQ-038 Reset asserted mid-instruction SHALL abort it with no further writes; first FETCH begins the first clk edge after reset=1.

Verification
REQ-039 Reset, memdata=0x0051 (ADD), memReady=1 -> FETCH,DECODE,ALU(ALUcond=0101,PSREN),WB(regWrite,PCEN) then FETCH; 4 cycles.
REQ-040 memReady=0 for 3 cycles in FETCH -> nextInstruction=0 held, state FETCH; asserted on 4th.
REQ-041 0xC005 BEQ with PSR=0x40 -> BranchEN=1, PCEN=1; PSR=0x00 -> BranchEN=0, PCEN=1.
REQ-042 0x4302 LOAD, memReady delayed 2 cycles -> regWrite=1,WriteData=0,PCEN=1 only in memReady cycle.
REQ-043 0x4184 JAL -> JAL cycle PCEN=1,chooseResult=11; JALWB regWrite=1,PCEN=0.
REQ-044 reset=0 during WB -> regWrite,PCEN drop to 0 same cycle; 0xF000 after reset -> PCINC, no regWrite.
